data_mem_responder: RTL and testbench

- Data-side responder for the CPU's data-memory port; the CPU is the initiator.
- Serves word, halfword and byte loads and stores to an on-chip RAM, with per-byte-lane writes.
- Also decodes a small memory-mapped interval-timer window. The timer raises a level interrupt that feeds the CPU's external interrupt input.
- Sits in the SoC top beside the instruction ROM, on the same clock as the core.

---
 rtl/data_mem_responder.sv | 174 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-side memory responder: byte-laned on-chip RAM with a zero-wait combinational
// read path, plus a small memory-mapped interval timer that drives a level interrupt.
module data_mem_responder #(
  parameter int          RAM_AW    = 10,
  parameter logic [31:0] MMIO_BASE = 32'h1FFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        int_o,
  output logic        err_o
);

  localparam int DEPTH = 1 << RAM_AW;

  localparam logic [1:0] OFF_LOAD   = 2'd0;
  localparam logic [1:0] OFF_COUNT  = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  logic              ram_hit;
  logic              mmio_hit;
  logic [RAM_AW-1:0] ram_idx;
  logic [1:0]        mmio_off;
  logic              ram_we;
  logic [31:0]       ram_rdata;
  logic [31:0]       mmio_rdata;

  logic [31:0] load_q,  load_d;
  logic [31:0] count_q, count_d;
  logic        en_q,    en_d;
  logic        auto_q,  auto_d;
  logic        ie_q,    ie_d;
  logic        pend_q,  pend_d;
  logic        err_q,   err_d;

  logic mmio_wr;
  logic load_wr;
  logic ctrl_wr;
  logic status_wr;
  logic arm;
  logic run;

  // Byte-lane offset within the word is carried by sel_i, not the address.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[1:0];

  assign ram_hit  = (addr_i[31:RAM_AW+2] == '0);
  assign mmio_hit = (addr_i[31:4] == MMIO_BASE[31:4]);
  assign ram_idx  = addr_i[RAM_AW+1:2];
  assign mmio_off = addr_i[3:2];

  assign ram_we = rst & ce_i & we_i & ram_hit;

  // One narrow array per byte lane so lane writes never touch neighbouring bytes.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : lane_g
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (ram_we && sel_i[gi]) begin
          lane_mem[ram_idx] <= data_i[8*gi +: 8];
        end
      end

      assign ram_rdata[8*gi +: 8] = lane_mem[ram_idx];
    end
  endgenerate

  always_comb begin
    mmio_rdata = '0;
    case (mmio_off)
      OFF_LOAD:   mmio_rdata = load_q;
      OFF_COUNT:  mmio_rdata = count_q;
      OFF_CTRL:   mmio_rdata = {29'd0, ie_q, auto_q, en_q};
      OFF_STATUS: mmio_rdata = {31'd0, pend_q};
      default:    mmio_rdata = '0;
    endcase
  end

  always_comb begin
    data_o = '0;
    if (rst && ce_i && !we_i) begin
      if (ram_hit) begin
        data_o = ram_rdata;
      end else if (mmio_hit) begin
        data_o = mmio_rdata;
      end
    end
  end

  assign mmio_wr   = rst & ce_i & we_i & mmio_hit;
  assign load_wr   = mmio_wr & (mmio_off == OFF_LOAD);
  assign ctrl_wr   = mmio_wr & (mmio_off == OFF_CTRL) & sel_i[0];
  assign status_wr = mmio_wr & (mmio_off == OFF_STATUS) & sel_i[0];
  assign arm       = ctrl_wr & data_i[0] & ~en_q;
  // A CTRL write that clears EN freezes COUNT on that very edge.
  assign run       = en_q & ~(ctrl_wr & ~data_i[0]);

  always_comb begin
    load_d = load_q;
    for (int i = 0; i < 4; i++) begin
      if (load_wr && sel_i[i]) begin
        load_d[8*i +: 8] = data_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    count_d = count_q;
    en_d    = en_q;
    auto_d  = auto_q;
    ie_d    = ie_q;
    pend_d  = pend_q;

    if (ctrl_wr) begin
      en_d   = data_i[0];
      auto_d = data_i[1];
      ie_d   = data_i[2];
    end

    if (status_wr && data_i[0]) begin
      pend_d = 1'b0;
    end

    // Expiry is evaluated after the clear so a same-edge expiry keeps PEND set.
    if (arm) begin
      count_d = load_q;
    end else if (run && count_q > 32'd1) begin
      count_d = count_q - 32'd1;
    end else if (run && count_q == 32'd1) begin
      pend_d = 1'b1;
      if (auto_q) begin
        count_d = load_q;
      end else begin
        count_d = '0;
        if (!ctrl_wr) begin
          en_d = 1'b0;
        end
      end
    end
  end

  assign err_d = ce_i & ~ram_hit & ~mmio_hit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      load_q  <= '0;
      count_q <= '0;
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      ie_q    <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      load_q  <= load_d;
      count_q <= count_d;
      en_q    <= en_d;
      auto_q  <= auto_d;
      ie_q    <= ie_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign int_o = pend_q & ie_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM lanes, timer one-shot/auto, error pulse, reset.
module tb_data_mem_responder;

  localparam logic [31:0] MB       = 32'h1FFF_0000;
  localparam logic [31:0] A_LOAD   = MB + 32'h0;
  localparam logic [31:0] A_COUNT  = MB + 32'h4;
  localparam logic [31:0] A_CTRL   = MB + 32'h8;
  localparam logic [31:0] A_STATUS = MB + 32'hC;

  logic        clk;
  logic        rst;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        int_o;
  logic        err_o;

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_responder #(.RAM_AW(10), .MMIO_BASE(MB)) dut (
    .clk    (clk),
    .rst    (rst),
    .ce_i   (ce_i),
    .we_i   (we_i),
    .addr_i (addr_i),
    .sel_i  (sel_i),
    .data_i (data_i),
    .data_o (data_o),
    .int_o  (int_o),
    .err_o  (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    ce_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d; sel_i = s;
    tick();
    ce_i = 1'b0; we_i = 1'b0; data_i = '0; sel_i = '0;
  endtask

  // Combinational load sampled within the same cycle; no clock edge consumed.
  task automatic load_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    ce_i = 1'b1; we_i = 1'b0; addr_i = a;
    #1;
    check_eq(tag, data_o, exp);
    ce_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ce_i = 1'b0; we_i = 1'b0; addr_i = '0; sel_i = '0; data_i = '0;
    tick();
    tick();
    check_eq("rst_int", {31'd0, int_o}, 32'd0);
    check_eq("rst_err", {31'd0, err_o}, 32'd0);
    rst = 1'b1;
    load_chk("rst_load",   A_LOAD,   32'd0);
    load_chk("rst_count",  A_COUNT,  32'd0);
    load_chk("rst_ctrl",   A_CTRL,   32'd0);
    load_chk("rst_status", A_STATUS, 32'd0);

    // RAM lane writes
    do_store(32'h10, 32'hDEADBEEF, 4'b1111);
    do_store(32'h10, 32'h000000AA, 4'b0001);
    load_chk("ram_byte_lane", 32'h10, 32'hDEADBEAA);
    check_eq("ram_err_mapped", {31'd0, err_o}, 32'd0);
    ce_i = 1'b0; we_i = 1'b0; addr_i = 32'h10;
    #1;
    check_eq("ram_ce0", data_o, 32'd0);
    do_store(32'h14, 32'h11223344, 4'b1111);
    do_store(32'h14, 32'hAABB0000, 4'b1100);
    load_chk("ram_half_lane", 32'h14, 32'hAABB3344);
    do_store(32'h14, 32'h00000000, 4'b0000);
    load_chk("ram_sel0", 32'h14, 32'hAABB3344);

    // One-shot timer, LOAD=5
    do_store(A_LOAD, 32'd5, 4'b1111);
    do_store(A_CTRL, 32'h5, 4'b0001);
    load_chk("os_count_arm", A_COUNT, 32'd5);
    for (int i = 0; i < 4; i++) tick();
    load_chk("os_count_e4", A_COUNT, 32'd1);
    load_chk("os_pend_e4", A_STATUS, 32'd0);
    check_eq("os_int_e4", {31'd0, int_o}, 32'd0);
    tick();
    load_chk("os_pend_e5", A_STATUS, 32'd1);
    check_eq("os_int_e5", {31'd0, int_o}, 32'd1);
    load_chk("os_count_e5", A_COUNT, 32'd0);
    load_chk("os_ctrl_e5", A_CTRL, 32'h4);
    do_store(A_STATUS, 32'd1, 4'b0001);
    load_chk("os_pend_clr", A_STATUS, 32'd0);
    check_eq("os_int_clr", {31'd0, int_o}, 32'd0);

    // Auto-reload timer, LOAD=3: counts 3,2,1,3,...
    do_store(A_LOAD, 32'd3, 4'b1111);
    do_store(A_CTRL, 32'h7, 4'b0001);
    load_chk("ar_count0", A_COUNT, 32'd3);
    tick();
    load_chk("ar_count1", A_COUNT, 32'd2);
    tick();
    load_chk("ar_count2", A_COUNT, 32'd1);
    tick();
    load_chk("ar_count3", A_COUNT, 32'd3);
    check_eq("ar_int3", {31'd0, int_o}, 32'd1);
    do_store(A_STATUS, 32'd1, 4'b0001);
    load_chk("ar_count4", A_COUNT, 32'd2);
    load_chk("ar_pend4", A_STATUS, 32'd0);
    tick();
    load_chk("ar_count5", A_COUNT, 32'd1);
    load_chk("ar_pend5", A_STATUS, 32'd0);
    tick();
    load_chk("ar_pend6", A_STATUS, 32'd1);
    load_chk("ar_count6", A_COUNT, 32'd3);

    // Clear on a non-expiry edge, then clear racing an expiry: set wins
    do_store(A_STATUS, 32'd1, 4'b0001);
    load_chk("race_pend_pre", A_STATUS, 32'd0);
    tick();
    load_chk("race_count", A_COUNT, 32'd1);
    do_store(A_STATUS, 32'd1, 4'b0001);
    load_chk("race_pend_set", A_STATUS, 32'd1);
    load_chk("race_count_rl", A_COUNT, 32'd3);
    do_store(A_STATUS, 32'd0, 4'b0001);
    load_chk("w0_pend", A_STATUS, 32'd1);
    load_chk("w0_count", A_COUNT, 32'd2);

    // Clearing EN freezes COUNT on the same edge
    do_store(A_CTRL, 32'h6, 4'b0001);
    load_chk("stop_count", A_COUNT, 32'd2);
    load_chk("stop_ctrl", A_CTRL, 32'h6);
    tick();
    load_chk("stop_hold", A_COUNT, 32'd2);

    // Unmapped access
    load_chk("unm_data", 32'h0000_2000, 32'd0);
    ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_2000;
    tick();
    ce_i = 1'b0;
    check_eq("unm_err_pulse", {31'd0, err_o}, 32'd1);
    tick();
    check_eq("unm_err_clear", {31'd0, err_o}, 32'd0);
    do_store(32'h0000_2010, 32'h0, 4'b1111);
    check_eq("unm_st_err", {31'd0, err_o}, 32'd1);
    load_chk("unm_st_ram", 32'h10, 32'hDEADBEAA);

    // Reset mid-count with LOAD=4, COUNT=2
    do_store(A_LOAD, 32'd4, 4'b1111);
    do_store(A_CTRL, 32'h5, 4'b0001);
    tick();
    tick();
    load_chk("mid_count", A_COUNT, 32'd2);
    check_eq("mid_int", {31'd0, int_o}, 32'd1);
    rst = 1'b0;
    ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h10; data_i = 32'h0; sel_i = 4'b1111;
    tick();
    we_i = 1'b0; sel_i = '0;
    #1;
    check_eq("rstl_data", data_o, 32'd0);
    check_eq("rstl_int", {31'd0, int_o}, 32'd0);
    check_eq("rstl_err", {31'd0, err_o}, 32'd0);
    ce_i = 1'b0;
    rst = 1'b1;
    load_chk("post_load",   A_LOAD,   32'd0);
    load_chk("post_count",  A_COUNT,  32'd0);
    load_chk("post_ctrl",   A_CTRL,   32'd0);
    load_chk("post_status", A_STATUS, 32'd0);
    load_chk("post_ram", 32'h10, 32'hDEADBEAA);
    tick();
    load_chk("post_count_hold", A_COUNT, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
